pipe_stage_reg: RTL and testbench
=================================

PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 SHALL have parameter DATA_W, default 64, payload width in bits (e.g. {pc, inst}).
REQ-002 SHALL have parameter BUBBLE_VAL, default all-zero, payload value presented when the stage holds no valid entry.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port in_valid  input  1  upstream offers in_data.
REQ-006 SHALL have port in_ready  output  1  stage accepts in_data this cycle.
REQ-007 SHALL have port in_data  input  DATA_W  upstream payload.
REQ-008 SHALL have port flush  input  1  discard all held entries.
REQ-009 SHALL have port out_valid  output  1  out_data is a valid entry.
REQ-010 SHALL have port out_ready  input  1  downstream consumes out_data this cycle.
REQ-011 SHALL have port out_data  output  DATA_W  oldest held payload, or BUBBLE_VAL when out_valid=0.
REQ-012 SHALL have port occupancy  output  2  number of held entries (0..2).

Function
REQ-013 Transfer in SHALL occur iff in_valid && in_ready; transfer out iff out_valid && out_ready.
REQ-014 Entries SHALL leave in acceptance order; no payload duplicated or lost except by flush.
REQ-015 Latency SHALL be one cycle: data accepted at edge N is on out_data after edge N, regardless of out_ready.
REQ-016 State machine (skid build): EMPTY, ONE, TWO; occupancy = 0/1/2.
REQ-017 EMPTY: in transfer -> ONE; else stay.
REQ-018 ONE: in and out both -> ONE (main reloaded); in only -> TWO (new entry into skid slot); out only -> EMPTY.
REQ-019 TWO: out -> ONE (skid moves to main); else stay; in_ready=0.
REQ-020 in_ready SHALL be a register output (state != TWO), with no combinational path from out_ready.
REQ-021 flush SHALL take priority over every transfer: next state EMPTY, both slots marked invalid, in_data of that cycle dropped; out_data shows BUBBLE_VAL the next cycle.
REQ-022 During a flush cycle in_ready SHALL read 1 (input consumed and discarded); out transfer that cycle is still counted as delivered.
REQ-023 out_valid and in_ready SHALL never both be X after reset; out_data SHALL equal BUBBLE_VAL whenever out_valid=0.

Reset
REQ-024 rst=1 SHALL immediately force state EMPTY, out_valid=0, occupancy=0, in_ready=1, out_data=BUBBLE_VAL, both slot registers=BUBBLE_VAL.
REQ-025 Reset asserted mid-transfer SHALL discard all entries; first accept possible on the first rising clk after rst deasserts.

Configuration
REQ-026 Macro PIPE_STAGE_SKID_EN SHALL select the build variant.
REQ-027 With PIPE_STAGE_SKID_EN defined: two-slot elastic stage per REQ-016..020.
REQ-028 Without it: single slot, states EMPTY/ONE only, in_ready = !out_valid || out_ready (combinational), occupancy max 1; all other requirements unchanged.

Structure
REQ-029 Package pipe_pkg SHALL hold the state enum (EMPTY, ONE, TWO) and default DATA_W constant.
REQ-030 One sub-module pipe_slot (DATA_W register with load/clear, reset to BUBBLE_VAL) SHALL be instantiated for main and skid slots.

Verification
REQ-031 Reset: rst pulse mid-stream with occupancy=2 -> out_valid=0, out_data=0, in_ready=1 within the same cycle.
REQ-032 Streaming: in_valid=1 every cycle, out_ready=1, data 1,2,3... -> out_data 1,2,3... one cycle later, occupancy=1 steady.
REQ-033 Backpressure (skid): out_ready=0 with data 0xA, 0xB offered -> occupancy=2, in_ready=0, out_data=0xA held; out_ready=1 -> 0xA then 0xB, no loss.
REQ-034 Flush: occupancy=2 plus in_valid=1 data 0xC with flush=1 -> next cycle occupancy=0, out_valid=0, out_data=BUBBLE_VAL; 0xC never appears.
REQ-035 No-skid build: out_ready=0, occupancy=1 -> in_ready=0; set out_ready=1 same cycle -> in_ready=1 combinationally and data replaced at the edge.
REQ-036 Random valid/ready/flush for 10k cycles against a reference queue model -> ordering and BUBBLE_VAL rules hold.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared state type and width default for the pipe_stage_reg block.
package pipe_pkg;

    localparam int DATA_W_DEF = 64;

    // Encodings equal the number of held entries.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } stage_state_e;

    function automatic logic [1:0] occ_of(input stage_state_e s);
        return 2'(s);
    endfunction

endpackage

// File: rtl/pipe_stage_reg_if.sv
// Handshake bundle for pipe_stage_reg: upstream side, downstream side and flush.
interface pipe_stage_reg_if
    import pipe_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
);

    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              flush;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [1:0]        occupancy;

    modport master (
        output in_valid, in_data, flush, out_ready,
        input  in_ready, out_valid, out_data, occupancy
    );

    modport slave (
        input  in_valid, in_data, flush, out_ready,
        output in_ready, out_valid, out_data, occupancy
    );

endinterface

// File: rtl/pipe_slot.sv
// One payload register of the stage; clear wins over load and returns it to BUBBLE_VAL.
module pipe_slot
    import pipe_pkg::*;
#(
    parameter int                DATA_W     = DATA_W_DEF,
    parameter logic [DATA_W-1:0] BUBBLE_VAL = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              clr,
    input  logic [DATA_W-1:0] d,
    output logic [DATA_W-1:0] q
);

    logic [DATA_W-1:0] data_d;
    logic [DATA_W-1:0] data_q;

    always_comb begin
        data_d = data_q;
        if (clr)
            data_d = BUBBLE_VAL;
        else if (load)
            data_d = d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            data_q <= BUBBLE_VAL;
        else
            data_q <= data_d;
    end

    assign q = data_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Elastic pipeline register. Define PIPE_STAGE_SKID_EN for the two-slot skid variant
// with a registered in_ready; the default build is a single slot with a pass-through ready.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int                DATA_W     = DATA_W_DEF,
    parameter logic [DATA_W-1:0] BUBBLE_VAL = '0
) (
    input logic             clk,
    input logic             rst,
    pipe_stage_reg_if.slave bus
);

    stage_state_e      state_q;
    stage_state_e      state_d;
    logic              out_valid_q;
    logic [1:0]        occupancy_q;
    logic              in_ready_w;
    logic              in_xfer;
    logic              out_xfer;
    logic              main_load;
    logic              main_clr;
    logic [DATA_W-1:0] main_d;
    logic [DATA_W-1:0] main_q;

`ifdef PIPE_STAGE_SKID_EN
    logic              in_ready_q;
    logic              skid_load;
    logic              skid_clr;
    logic [DATA_W-1:0] skid_q;

    // Flush consumes and drops the input even when both slots are full.
    assign in_ready_w = in_ready_q | bus.flush;
`else
    assign in_ready_w = !out_valid_q || bus.out_ready || bus.flush;
`endif

    assign in_xfer  = bus.in_valid && in_ready_w;
    assign out_xfer = out_valid_q && bus.out_ready;

    always_comb begin
        state_d   = state_q;
        main_load = 1'b0;
        main_clr  = 1'b0;
        main_d    = bus.in_data;
`ifdef PIPE_STAGE_SKID_EN
        skid_load = 1'b0;
        skid_clr  = 1'b0;
`endif
        if (bus.flush) begin
            state_d  = EMPTY;
            main_clr = 1'b1;
`ifdef PIPE_STAGE_SKID_EN
            skid_clr = 1'b1;
`endif
        end else begin
            case (state_q)
                EMPTY: begin
                    if (in_xfer) begin
                        state_d   = ONE;
                        main_load = 1'b1;
                    end
                end
                ONE: begin
                    if (in_xfer && out_xfer) begin
                        main_load = 1'b1;
                    end else if (out_xfer) begin
                        state_d  = EMPTY;
                        main_clr = 1'b1;
`ifdef PIPE_STAGE_SKID_EN
                    end else if (in_xfer) begin
                        state_d   = TWO;
                        skid_load = 1'b1;
`endif
                    end
                end
`ifdef PIPE_STAGE_SKID_EN
                TWO: begin
                    if (out_xfer) begin
                        state_d   = ONE;
                        main_load = 1'b1;
                        main_d    = skid_q;
                        skid_clr  = 1'b1;
                    end
                end
`endif
                default: state_d = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= EMPTY;
            out_valid_q <= 1'b0;
            occupancy_q <= 2'd0;
`ifdef PIPE_STAGE_SKID_EN
            in_ready_q  <= 1'b1;
`endif
        end else begin
            state_q     <= state_d;
            out_valid_q <= (state_d != EMPTY);
            occupancy_q <= occ_of(state_d);
`ifdef PIPE_STAGE_SKID_EN
            in_ready_q  <= (state_d != TWO);
`endif
        end
    end

    pipe_slot #(
        .DATA_W     (DATA_W),
        .BUBBLE_VAL (BUBBLE_VAL)
    ) u_main (
        .clk  (clk),
        .rst  (rst),
        .load (main_load),
        .clr  (main_clr),
        .d    (main_d),
        .q    (main_q)
    );

`ifdef PIPE_STAGE_SKID_EN
    pipe_slot #(
        .DATA_W     (DATA_W),
        .BUBBLE_VAL (BUBBLE_VAL)
    ) u_skid (
        .clk  (clk),
        .rst  (rst),
        .load (skid_load),
        .clr  (skid_clr),
        .d    (bus.in_data),
        .q    (skid_q)
    );
`endif

    // main slot is cleared whenever the stage empties, so it doubles as the bubble output.
    assign bus.in_ready  = in_ready_w;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = main_q;
    assign bus.occupancy = occupancy_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench for pipe_stage_reg; follows PIPE_STAGE_SKID_EN to pick the expected capacity.
module tb_pipe_stage_reg;
    import pipe_pkg::*;

    localparam int            DW  = DATA_W_DEF;
    localparam logic [DW-1:0] BUB = '0;
`ifdef PIPE_STAGE_SKID_EN
    localparam int CAP = 2;
`else
    localparam int CAP = 1;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pipe_stage_reg_if #(.DATA_W(DW)) bus ();

    pipe_stage_reg #(
        .DATA_W     (DW),
        .BUBBLE_VAL (BUB)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int            n_tests = 0;
    int            n_fail  = 0;
    logic [DW-1:0] sb_q[$];

    task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Drive one cycle from just after a rising edge; check at the falling edge, retire at the next rise.
    task automatic step(input logic iv, input logic [DW-1:0] id, input logic fl, input logic ordy);
        logic exp_rdy;
        logic exp_vld;
        logic in_x;
        logic out_x;
        bus.in_valid  = iv;
        bus.in_data   = id;
        bus.flush     = fl;
        bus.out_ready = ordy;
        @(negedge clk);
        exp_vld = (sb_q.size() != 0);
`ifdef PIPE_STAGE_SKID_EN
        exp_rdy = (sb_q.size() < CAP) || fl;
`else
        exp_rdy = (sb_q.size() == 0) || ordy || fl;
`endif
        chk("in_ready", DW'(bus.in_ready), DW'(exp_rdy));
        chk("out_valid", DW'(bus.out_valid), DW'(exp_vld));
        chk("occupancy", DW'(bus.occupancy), DW'(sb_q.size()));
        chk("out_data", bus.out_data, exp_vld ? sb_q[0] : BUB);
        in_x  = iv && exp_rdy;
        out_x = exp_vld && ordy;
        @(posedge clk);
        if (fl) begin
            sb_q.delete();
        end else begin
            if (out_x)
                void'(sb_q.pop_front());
            if (in_x)
                sb_q.push_back(id);
        end
        #1;
    endtask

    task automatic do_reset(input string tag);
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b0;
        #1;
        chk({tag, "_out_valid"}, DW'(bus.out_valid), '0);
        chk({tag, "_out_data"}, bus.out_data, BUB);
        chk({tag, "_in_ready"}, DW'(bus.in_ready), DW'(1));
        chk({tag, "_occupancy"}, DW'(bus.occupancy), '0);
        sb_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        logic          r_iv;
        logic          r_fl;
        logic          r_ordy;
        logic [DW-1:0] r_data;

        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b0;
        do_reset("por");

        // Streaming with a ready sink: one-cycle latency, occupancy steady at 1.
        for (int i = 1; i <= 8; i++)
            step(1'b1, DW'(i), 1'b0, 1'b1);
        step(1'b0, '0, 1'b0, 1'b1);

        // Backpressure, then release: skid holds A,B; single slot swaps B in on the ready edge.
        step(1'b1, 64'hA, 1'b0, 1'b0);
        step(1'b1, 64'hB, 1'b0, 1'b0);
        step(1'b1, 64'hB, 1'b0, 1'b1);
        step(1'b0, '0, 1'b0, 1'b1);
        step(1'b0, '0, 1'b0, 1'b1);

        // Flush while full with a new offer that must never surface.
        step(1'b1, 64'h1, 1'b0, 1'b0);
        step(1'b1, 64'h2, 1'b0, 1'b0);
        step(1'b1, 64'hC, 1'b1, 1'b0);
        step(1'b0, '0, 1'b0, 1'b1);
        step(1'b1, 64'h5, 1'b0, 1'b1);
        step(1'b0, '0, 1'b0, 1'b1);

        // Reset while holding entries, then the first edge after release accepts.
        step(1'b1, 64'h11, 1'b0, 1'b0);
        step(1'b1, 64'h22, 1'b0, 1'b0);
        do_reset("mid");
        step(1'b1, 64'h33, 1'b0, 1'b1);
        step(1'b0, '0, 1'b0, 1'b1);

        for (int n = 0; n < 10000; n++) begin
            r_iv   = 1'($urandom_range(0, 1));
            r_ordy = 1'($urandom_range(0, 1));
            r_fl   = ($urandom_range(0, 31) == 0);
            r_data = {$urandom, $urandom};
            step(r_iv, r_data, r_fl, r_ordy);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
